// File: rtl/mem_subword_ctrl.sv
// Sub-word access controller for a word-only synchronous SRAM (no byte enables).
// Loads extract a big-endian byte/halfword lane and extend it; sub-word stores do a
// read-modify-write of the containing word; word stores write directly.
module mem_subword_ctrl #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    // Errors skip straight to the response state so they complete one cycle after acceptance.
    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StCap,
        StRsp
    } state_e;

    state_e              state_q;
    logic                we_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;

    logic                req_err;
    logic [31:0]         load_data;
    logic [31:0]         merge_data;

    // Address bits above the SRAM range do not participate.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    // Misalignment / illegal size check on the incoming request.
    always_comb begin
        req_err = 1'b0;
        unique case (req_size)
            SizeByte: req_err = 1'b0;
            SizeHalf: req_err = req_addr[0];
            SizeWord: req_err = (req_addr[1:0] != 2'b00);
            default:  req_err = 1'b1;
        endcase
    end

    // Lane extraction and sign/zero extension of the returned SRAM word.
    always_comb begin
        logic [7:0]  lane8;
        logic [15:0] lane16;
        lane8     = 8'h00;
        lane16    = 16'h0000;
        load_data = 32'h0;
        unique case (addr_q[1:0])
            2'b00:   lane8 = mem_rdata[31:24];
            2'b01:   lane8 = mem_rdata[23:16];
            2'b10:   lane8 = mem_rdata[15:8];
            default: lane8 = mem_rdata[7:0];
        endcase
        lane16 = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        unique case (size_q)
            SizeByte: load_data = {{24{signed_q & lane8[7]}}, lane8};
            SizeHalf: load_data = {{16{signed_q & lane16[15]}}, lane16};
            default:  load_data = mem_rdata;
        endcase
    end

    // Replace only the target lane of the word read back during RD.
    always_comb begin
        merge_data = mem_rdata;
        if (size_q == SizeHalf) begin
            if (addr_q[1]) merge_data[15:0]  = wdata_q[15:0];
            else           merge_data[31:16] = wdata_q[15:0];
        end else begin
            unique case (addr_q[1:0])
                2'b00:   merge_data[31:24] = wdata_q[7:0];
                2'b01:   merge_data[23:16] = wdata_q[7:0];
                2'b10:   merge_data[15:8]  = wdata_q[7:0];
                default: merge_data[7:0]   = wdata_q[7:0];
            endcase
        end
    end

    // SRAM interface decoded from state; all zero outside RD/WR.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (state_q == StRd || state_q == StWr) begin
            mem_en   = 1'b1;
            mem_addr = addr_q[ADDR_W+1:2];
        end
        if (state_q == StWr) begin
            mem_we    = 1'b1;
            mem_wdata = (size_q == SizeWord) ? wdata_q : merge_data;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StRsp);

    // Request latch, control FSM and registered response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        addr_q    <= req_addr[ADDR_W+1:0];
                        wdata_q   <= req_wdata;
                        rsp_err   <= req_err;
                        rsp_rdata <= 32'h0;
                        if (req_err)                           state_q <= StRsp;
                        else if (req_we && req_size == SizeWord) state_q <= StWr;
                        else                                   state_q <= StRd;
                    end
                end
                StRd:    state_q <= we_q ? StWr : StCap;
                StWr:    state_q <= StRsp;
                StCap: begin
                    rsp_rdata <= load_data;
                    state_q   <= StRsp;
                end
                StRsp:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
